// File: rtl/rr_sel_arb.sv
// rr_sel_arb: four-source round-robin arbiter driving a downstream mux4.
//
// A request seen in IDLE is granted on the next edge, searching from the
// round-robin pointer. The grant is held for up to MAX_BURST cycles. It ends
// early when the grantee raises done or drops its request. Every grant is
// followed by exactly one IDLE cycle. After a release the pointer moves one
// past the released source.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst_n  - asynchronous active-low reset
//   req    - per-source request, bit i = mux4 input din_i
//   done   - current grantee finished early (ignored in IDLE)
//   sel    - registered mux4 select, holds the last granted index
//   grant  - registered one-hot grant, zero when idle
//   busy   - high while in GRANT
module rr_sel_arb #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] sel_n;
    logic [3:0] grant_n;
    logic [3:0] beat_cnt, beat_n;
    logic [1:0] pick;
    logic       release_now;

    // First set request in the order ptr, ptr+1, ptr+2, ptr+3.
    // The loop walks downward so the lowest offset is written last and wins.
    always_comb begin
        pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
        end
    end

    // Any one release cause is enough, and several at once act as one.
    assign release_now = done || !req[sel] || (beat_cnt == 4'(MAX_BURST - 1));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        grant_n = grant;
        beat_n  = beat_cnt;
        case (state)
            IDLE: begin
                grant_n = 4'b0000;
                if (req != 4'b0000) begin
                    state_n = GRANT;
                    sel_n   = pick;
                    grant_n = 4'b0001 << pick;
                    beat_n  = 4'd0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_n = IDLE;
                    grant_n = 4'b0000;
                    ptr_n   = sel + 2'd1;
                end else if (beat_cnt != 4'hF) begin
                    // Saturate so the counter can never wrap.
                    beat_n = beat_cnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            sel      <= 2'd0;
            grant    <= 4'b0000;
            beat_cnt <= 4'd0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            sel      <= sel_n;
            grant    <= grant_n;
            beat_cnt <= beat_n;
        end
    end

    // state is itself a flop, so busy is a registered output.
    assign busy = (state == GRANT);

endmodule
